// File: rtl/gray_sync_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_sync_decoder_if
// Description : Bundles the Gray input, tracking enable and decoded status
//               outputs of gray_sync_decoder. The master modport belongs to
//               the side that supplies the Gray code and consumes the results.
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_sync_decoder_if #(
  parameter int NUM   = 6,
  parameter int CNT_W = 8
);
  logic [NUM-1:0]   g_in;
  logic             en;
  logic [NUM-1:0]   b_out;
  logic             b_valid;
  logic             step_up;
  logic             step_down;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output g_in, en,
    input  b_out, b_valid, step_up, step_down, err, err_count
  );

  modport slave (
    input  g_in, en,
    output b_out, b_valid, step_up, step_down, err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/gray_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray_sync_decoder
// Description : Synchronizes a foreign-domain Gray count into clk, decodes it
//               to binary and classifies each change as +1, -1 or an illegal
//               multi-bit jump, with a saturating error counter.
//               Optional macro GRAY_SYNC_STICKY_ERR_EN makes err sticky until
//               en is deasserted or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_sync_decoder #(
  parameter int NUM         = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  gray_sync_decoder_if.slave bus
);

  localparam logic [NUM-1:0]   c_ONE_B   = NUM'(1);
  localparam logic [CNT_W-1:0] c_ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_t;

  logic [NUM-1:0]   r_sync [SYNC_STAGES];
  logic [NUM-1:0]   w_g_s;
  logic [NUM-1:0]   w_b;
  logic [NUM-1:0]   w_diff;
  logic [NUM-1:0]   w_delta;
  logic             w_one_bit;

  state_t           r_state,  w_state_nxt;
  logic [NUM-1:0]   r_prev_g, w_prev_g_nxt;
  logic [NUM-1:0]   r_b_out,  w_b_out_nxt;
  logic             r_b_valid, w_b_valid_nxt;
  logic             r_step_up, w_step_up_nxt;
  logic             r_step_dn, w_step_dn_nxt;
  logic             r_err,     w_err_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;

  // First synchronizer flop: the only place g_in is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync[0] <= '0;
    else          r_sync[0] <= bus.g_in;
  end

  generate
    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
      // Remaining synchronizer stages, free-running regardless of en.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync[i] <= '0;
        else          r_sync[i] <= r_sync[i-1];
      end
    end
  endgenerate

  assign w_g_s = r_sync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_b = '0;
    for (int i = 0; i < NUM; i++) begin
      w_b[i] = ^(w_g_s >> i);
    end
  end

  // Exactly one differing bit means a legal step; the sign of the modular
  // binary difference gives its direction.
  assign w_diff    = w_g_s ^ r_prev_g;
  assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - c_ONE_B)) == '0);
  assign w_delta   = w_b - r_b_out;

  // Next-state and registered-output logic for the ACQ/TRACK tracker.
  always_comb begin
    w_state_nxt   = r_state;
    w_prev_g_nxt  = r_prev_g;
    w_b_out_nxt   = r_b_out;
    w_b_valid_nxt = r_b_valid;
    w_step_up_nxt = 1'b0;
    w_step_dn_nxt = 1'b0;
`ifdef GRAY_SYNC_STICKY_ERR_EN
    w_err_nxt     = r_err;
`else
    w_err_nxt     = 1'b0;
`endif
    w_err_cnt_nxt = r_err_cnt;

    case (r_state)
      ACQ: begin
        w_err_nxt = 1'b0;
        if (bus.en) begin
          w_prev_g_nxt  = w_g_s;
          w_b_out_nxt   = w_b;
          w_b_valid_nxt = 1'b1;
          w_state_nxt   = TRACK;
        end else begin
          w_b_valid_nxt = 1'b0;
        end
      end
      TRACK: begin
        if (!bus.en) begin
          // Enable loss wins over any concurrent input change.
          w_state_nxt   = ACQ;
          w_b_valid_nxt = 1'b0;
          w_err_nxt     = 1'b0;
        end else if (w_diff != '0) begin
          w_prev_g_nxt = w_g_s;
          w_b_out_nxt  = w_b;
          if (w_one_bit) begin
            w_step_up_nxt = ~w_delta[NUM-1];
            w_step_dn_nxt =  w_delta[NUM-1];
          end else begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != c_CNT_MAX) w_err_cnt_nxt = r_err_cnt + c_ONE_CNT;
          end
        end
      end
      default: w_state_nxt = ACQ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ACQ;
      r_prev_g  <= '0;
      r_b_out   <= '0;
      r_b_valid <= 1'b0;
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev_g  <= w_prev_g_nxt;
      r_b_out   <= w_b_out_nxt;
      r_b_valid <= w_b_valid_nxt;
      r_step_up <= w_step_up_nxt;
      r_step_dn <= w_step_dn_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bus.b_out     = r_b_out;
  assign bus.b_valid   = r_b_valid;
  assign bus.step_up   = r_step_up;
  assign bus.step_down = r_step_dn;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
- Receiving stage directly downstream of the 6-bit binary-to-Gray converter.
- Brings a Gray-coded count from a foreign clock domain into the local clock domain through a flop synchronizer chain.
- Decodes the synchronized Gray value back to a registered binary value.
- Classifies each observed change as a +1 step, a -1 step or an illegal multi-bit jump.
- Feeds local counters and status logic that consume the binary count.

Parameters:
NUM, 6, Gray/binary word width in bits (legal range 2..16)
SYNC_STAGES, 2, number of synchronizer flops on g_in (legal range 2..4)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  local clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset, deassertion synchronous to clk externally
g_in  input  NUM  Gray code from the converter, asynchronous to clk
en  input  1  tracking enable; low forces re-acquisition
b_out  output  NUM  registered binary decode of the synchronized Gray value
b_valid  output  1  b_out holds a value captured since the last (re)acquisition
step_up  output  1  one-cycle pulse: new binary value = previous + 1 mod 2^NUM
step_down  output  1  one-cycle pulse: new binary value = previous - 1 mod 2^NUM
err  output  1  illegal transition indicator (Hamming distance > 1 between successive synchronized Gray values)
err_count  output  CNT_W  saturating count of err events since reset

Behaviour:
- Reset (reset_n low, asynchronous):
  - All sync flops = 0, prev_g = 0.
  - b_out = 0, b_valid = 0, step_up = step_down = err = 0, err_count = 0.
  - FSM = ACQ.
- Synchronizer:
  - g_in passes through SYNC_STAGES flops every cycle regardless of en; the last stage is g_s.
  - No logic reads g_in or intermediate stages.
- Decode (combinational on g_s):
  - b[NUM-1] = g_s[NUM-1].
  - b[i] = b[i+1] XOR g_s[i] for i = NUM-2 down to 0.
- FSM states: ACQ, TRACK.
  - ACQ, en=1:
    - Capture prev_g <= g_s, b_out <= b.
    - b_valid <= 1, go to TRACK.
    - No step or err on the capture cycle.
  - ACQ, en=0: hold b_out; b_valid = 0.
  - TRACK, en=0: go to ACQ next cycle; b_valid <= 0; b_out holds its last value.
  - TRACK, en=1, g_s == prev_g: no change; all pulses 0.
  - TRACK, en=1, Hamming(g_s, prev_g) == 1:
    - prev_g <= g_s, b_out <= b.
    - step_up or step_down pulses according to the modular direction.
  - TRACK, en=1, Hamming > 1:
    - prev_g <= g_s, b_out <= b (resynchronize to the new value).
    - err pulses, step_up and step_down stay 0.
    - err_count increments, saturating at 2^CNT_W - 1.
- Wrap-around:
  - Binary 2^NUM-1 -> 0 is step_up.
  - 0 -> 2^NUM-1 is step_down.
- Outputs are all registered; pulses last exactly one cycle.
- Latency: a stable change on g_in appears on b_out and the pulses SYNC_STAGES+1 rising edges later.
- Simultaneous events: en falling in the same cycle as a g_s change means no update and no pulse; the FSM goes to ACQ.
- Reset mid-operation: immediate return to the reset values, including err_count.

Optional Feature:
- Macro: GRAY_SYNC_STICKY_ERR_EN.
- Defined:
  - err is sticky: set on an illegal transition and held high until en is deasserted (ACQ entry clears it) or reset.
  - err_count still increments once per illegal transition.
- Undefined: err is a single-cycle pulse per illegal transition.

Test Plan:
- Reset then en=1, g_in=000111 held -> b_out=000101 (5), b_valid=1 at cycle SYNC_STAGES+1; no step or err pulses.
- From 5, g_in 000111->000101 -> b_out=000110 (6), step_up=1 for one cycle, SYNC_STAGES+1 cycles after the change.
- From 0 (g=000000), g_in->100000 -> b_out=111111 (63), step_down pulse; then g_in->000000 -> b_out=0, step_up pulse (wrap).
- From g=000000, g_in->000011 -> err=1 one cycle (sticky when the macro is defined), b_out=000010, err_count=1; repeat 300 illegal jumps -> err_count saturates at 255.
- en=0 for 5 cycles while g_in walks 3 codes -> b_valid=0, b_out frozen; en=1 -> recapture with no err or step, b_valid=1 next cycle.
- Assert reset_n low mid-TRACK with err_count=4 -> all outputs 0 asynchronously; after release and en=1, normal acquisition.
